// File: rtl/adder_serial_n_bit.sv
// adder_serial_n_bit: N-bit adder that sums CHUNK bits per clock, rippling the carry through a register.
// Optional feature macro ADDER_SERIAL_OVF_EN adds a registered signed-overflow output ovf.

module adder_serial_n_bit_chk (
  input logic clk,
  input logic rst,
  input logic in_valid,
  input logic out_ready,
  input logic in_ready,
  input logic out_valid
);
  // Handshake inputs must never be unknown outside reset.
  a_in_valid_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(in_valid))
    else $error("in_valid is X/Z");
  a_out_ready_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(out_ready))
    else $error("out_ready is X/Z");
  // A pending result and a new acceptance never coexist.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid))
    else $error("in_ready and out_valid high together");
endmodule

module adder_serial_n_bit #(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
`ifdef ADDER_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_param
    $error("adder_serial_n_bit: illegal N=%0d / CHUNK=%0d", N, CHUNK);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [N-1:0]    sum_q;
  logic            cout_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            busy_q;
`ifdef ADDER_SERIAL_OVF_EN
  logic            ovf_q;
`endif

  logic [CHUNK-1:0] a_chunk_d;
  logic [CHUNK-1:0] b_chunk_d;
  logic [CHUNK:0]   step_d;
  logic [N-1:0]     sum_next_d;

  // Select the active chunk, add it with the rippled carry and merge it into the partial sum.
  always_comb begin
    a_chunk_d  = '0;
    b_chunk_d  = '0;
    sum_next_d = sum_q;
    for (int k = 0; k < NCHUNK; k++) begin
      a_chunk_d = a_chunk_d | ((idx_q == IDXW'(k)) ? a_q[k*CHUNK +: CHUNK] : {CHUNK{1'b0}});
      b_chunk_d = b_chunk_d | ((idx_q == IDXW'(k)) ? b_q[k*CHUNK +: CHUNK] : {CHUNK{1'b0}});
    end
    step_d = {1'b0, a_chunk_d} + {1'b0, b_chunk_d} + {{CHUNK{1'b0}}, carry_q};
    for (int k = 0; k < NCHUNK; k++) begin
      sum_next_d[k*CHUNK +: CHUNK] = (idx_q == IDXW'(k)) ? step_d[CHUNK-1:0]
                                                         : sum_q[k*CHUNK +: CHUNK];
    end
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_next_d;
          carry_q <= step_d[CHUNK];
          if (idx_q == IDX_LAST) begin
            // idx stays parked on the last chunk rather than wrapping.
            cout_q      <= step_d[CHUNK];
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`ifdef ADDER_SERIAL_OVF_EN
            ovf_q       <= signed_ovf(a_q[N-1], b_q[N-1], sum_next_d[N-1]);
`endif
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;
`ifdef ADDER_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

  adder_serial_n_bit_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready_q),
    .out_valid (out_valid_q)
  );

endmodule

// File: tb/tb_adder_serial_n_bit.sv
// Self-checking bench for adder_serial_n_bit: directed table, handshake corner cases,
// randomized operands against an arithmetic reference, and a CHUNK sweep (1, 2, 8).
module tb_adder_serial_n_bit;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, cin, out_ready;
  logic [N-1:0] a, b;
  logic         in_ready, out_valid, cout, busy;
  logic [N-1:0] sum;
  logic         c1_in_ready, c1_out_valid, c1_cout, c1_busy;
  logic [N-1:0] c1_sum;
  logic         c8_in_ready, c8_out_valid, c8_cout, c8_busy;
  logic [N-1:0] c8_sum;
`ifdef ADDER_SERIAL_OVF_EN
  logic         ovf, c1_ovf, c8_ovf;
`endif

  adder_serial_n_bit #(.N(N), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  adder_serial_n_bit #(.N(N), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c1_in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(c1_out_valid), .out_ready(out_ready), .sum(c1_sum), .cout(c1_cout), .busy(c1_busy)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(c1_ovf)
`endif
  );

  adder_serial_n_bit #(.N(N), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c8_in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(c8_out_valid), .out_ready(out_ready), .sum(c8_sum), .cout(c8_cout), .busy(c8_busy)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(c8_ovf)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t         tbl[10];
  logic [N-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  int           res_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [N:0] ref_add(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    int r;
    r = int'(va) + int'(vb) + int'(vc);
    return r[N:0];
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    int sa, sb, r;
    sa = (int'(va) >= 2**(N-1)) ? int'(va) - 2**N : int'(va);
    sb = (int'(vb) >= 2**(N-1)) ? int'(vb) - 2**N : int'(vb);
    r  = sa + sb + int'(vc);
    return (r > 2**(N-1) - 1) || (r < -(2**(N-1)));
  endfunction

  // Present operands and return #1 after the accepting edge (E0).
  task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    int k;
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("accept_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen; res_lat stays -1 on timeout.
  task automatic wait_result();
    res_lat = -1;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        res_lat  = t;
        res_sum  = sum;
        res_cout = cout;
`ifdef ADDER_SERIAL_OVF_EN
        res_ovf  = ovf;
`else
        res_ovf  = 1'b0;
`endif
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic vc, input logic [N-1:0] es, input logic ec, input logic eo);
    send(va, vb, vc);
    wait_result();
    chk({name, "_lat"}, 32'(res_lat), 32'd4);
    chk({name, "_sum"}, {23'd0, res_cout, res_sum}, {23'd0, ec, es});
`ifdef ADDER_SERIAL_OVF_EN
    chk({name, "_ovf"}, {31'd0, res_ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) chk({name, "_ovf_x"}, 32'd1, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk({name, "_after"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic         seen;
    logic [N:0]   exp;
    logic [N-1:0] ra, rb;
    logic         rc;
    int           l1, l2, l8;
    logic [N:0]   r1, r2, r8;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {22'd0, out_valid, busy, cout, sum}, 32'd0);
    chk("rst_other_busy", {30'd0, c1_busy, c8_busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {29'd0, in_ready, c1_in_ready, c8_in_ready}, 32'd7);

    // Directed table.
    tbl[0] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[8] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[9] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c, tbl[i].o);
    end

    // Backpressure with the next operands already waiting on in_valid.
    out_ready = 1'b0;
    send(8'h5A, 8'hA5, 1'b1);
    a = 8'h03; b = 8'h04; cin = 1'b0; in_valid = 1'b1;
    wait_result();
    chk("bp_lat", 32'(res_lat), 32'd4);
    chk("bp_sum", {23'd0, res_cout, res_sum}, {23'd0, 1'b1, 8'h00});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", i), {22'd0, out_valid, in_ready, cout, sum}, {22'd0, 1'b1, 1'b0, 1'b1, 8'h00});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept", {30'd0, in_ready, busy}, {30'd0, 1'b0, 1'b1});
    wait_result();
    chk("bp_next_lat", 32'(res_lat), 32'd4);
    chk("bp_next_sum", {23'd0, res_cout, res_sum}, {23'd0, 1'b0, 8'h07});
    @(posedge clk);
    #1;

    // Reset in the middle of an add.
    send(8'hF0, 8'h10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_outs", {22'd0, out_valid, busy, cout, sum}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("midrst_no_pulse", {31'd0, seen}, 32'd0);
    run_op("midrst_next", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp = ref_add(ra, rb, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, exp[N-1:0], exp[N], ref_ovf(ra, rb, rc));
    end

    // CHUNK sweep: all three instances start together after a reset.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    l1 = -1; l2 = -1; l8 = -1;
    r1 = '0; r2 = '0; r8 = '0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      #1;
      if (c1_out_valid && l1 < 0) begin l1 = t; r1 = {c1_cout, c1_sum}; end
      if (out_valid && l2 < 0)    begin l2 = t; r2 = {cout, sum}; end
      if (c8_out_valid && l8 < 0) begin l8 = t; r8 = {c8_cout, c8_sum}; end
    end
    chk("sweep_c1_lat", 32'(l1), 32'd8);
    chk("sweep_c2_lat", 32'(l2), 32'd4);
    chk("sweep_c8_lat", 32'(l8), 32'd1);
    chk("sweep_c1_sum", {23'd0, r1}, {23'd0, 9'h100});
    chk("sweep_c2_sum", {23'd0, r2}, {23'd0, 9'h100});
    chk("sweep_c8_sum", {23'd0, r8}, {23'd0, 9'h100});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_serial_n_bit.md
Name: adder_serial_n_bit

Overview:
Parametrised, multi-cycle successor to the combinational N-bit adder. Adds two N-bit operands plus carry-in CHUNK bits per clock, rippling the carry through a register between cycles, so wide adds close timing. Valid/ready handshakes on both sides let it sit between pipeline stages or sync-FIFO endpoints in the datapath.

Parameters:
N, 8, operand/sum width in bits; must be >= 1
CHUNK, 2, bits added per clock; 1 <= CHUNK <= N and N % CHUNK == 0, else $error at elaboration
NCHUNK, N/CHUNK, derived localparam: cycles per add

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  N  operand A
b  input  N  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout valid
out_ready  input  1  downstream accepts result
sum  output  N  registered sum, (a+b+cin) mod 2^N
cout  output  1  registered carry-out, bit N of a+b+cin
busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous and active-high. Reset on a clk edge with rst=1 takes priority over all other inputs.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, busy=0. in_ready=1 from the first edge after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1 at an edge, latch a, b, cin into internal registers, set chunk index idx=0 and carry=cin, then go to RUN. If in_valid=0, stay in IDLE.
- RUN: in_ready=0, busy=1. Each edge performs one chunk step:
  - Compute {c, s} = a_reg[idx*CHUNK +: CHUNK] + b_reg[idx*CHUNK +: CHUNK] + carry, which is CHUNK+1 bits wide.
  - Write s into sum_reg[idx*CHUNK +: CHUNK], set carry=c, and increment idx.
  - On the step where idx=NCHUNK-1, load cout=c and go to DONE.
- idx width: max(1, $clog2(NCHUNK)). idx never wraps past NCHUNK-1.
- Latency: the accept edge is E0. The chunk steps happen at E1..E_NCHUNK. out_valid rises after E_NCHUNK, i.e. NCHUNK cycles after acceptance. With CHUNK=N this is 1 cycle.
- DONE: out_valid=1; sum and cout are stable. If out_ready=1 at an edge, the result transfers, out_valid falls and the FSM returns to IDLE. Otherwise sum, cout and out_valid hold indefinitely.
- in_ready stays 0 through RUN and DONE. There is no overlap between a pending result and a new acceptance. Peak throughput is one add per NCHUNK+2 cycles.
- The published sum/cout only becomes meaningful when out_valid=1. During RUN, sum shows the partial result and the bench must not check it.
- Input changes during RUN/DONE are ignored, because operands are latched at acceptance.
- rst during RUN or DONE aborts the operation: outputs go to reset values, no out_valid pulse occurs, and in_ready=1 on the next cycle.
- X on in_valid or out_ready is not tolerated; assertions flag it in simulation.

Optional Feature:
ADDER_SERIAL_OVF_EN
- Defined: extra output port ovf (1 bit), registered alongside cout. ovf = two's-complement signed overflow = (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]), computed from the latched operands and final sum. It is valid with out_valid and reset to 0.
- Undefined: the ovf port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: hold rst=1 for 3 cycles, then release -> out_valid=0, sum=0, cout=0, busy=0 at release; in_ready=1 on the first cycle after release.
2. N=8, CHUNK=2: a=8'h00, b=8'h00, cin=1 accepted at E0, out_ready=1 -> out_valid high exactly after E4 for one cycle; sum=8'h01, cout=0; in_ready returns to 1 afterwards.
3. Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 after 4 cycles; repeat with CHUNK=1 (8 cycles) and CHUNK=8 (1 cycle), same result.
4. Backpressure: a=8'h5A, b=8'hA5, cin=1, with out_ready=0 for 3 cycles after out_valid rises -> sum=8'h00, cout=1 held stable and out_valid stays 1. Next operands (a=8'h03, b=8'h04, cin=0) are held on in_valid throughout; they are not accepted until after the handshake, then give sum=8'h07, cout=0.
5. Reset mid-op: assert rst for 1 cycle at E2 of an add of a=8'hF0, b=8'h10 -> no out_valid pulse, sum=0, cout=0; in_ready=1 on the next cycle; a following add of 8'h01+8'h01 gives 8'h02.
6. Only with ADDER_SERIAL_OVF_EN defined: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'hFF, cin=0 -> sum=8'h7F, cout=1, ovf=1; a=8'h10, b=8'h20 -> ovf=0.
